// File: rtl/parallel_scrambler.sv
// x^7+x^4+1 additive scrambler/descrambler, DATA_W bits per beat, valid/ready in and out.
// Define SCRAMBLER_SEED_RECOVERY_EN to add ACQ (seed recovery from 7 zero SERVICE bits).
module parallel_scrambler #(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clock,
    input  logic              Scrambler_Reset_n,
    input  logic              Scrambler_Start,
    input  logic [6:0]        Scrambler_InitialState,
    input  logic [DATA_W-1:0] Scrambler_DataIN,
    input  logic              Scrambler_DataIN_VALID,
    output logic              Scrambler_DataIN_READY,
    output logic [DATA_W-1:0] Scrambler_DataOUT,
    output logic              Scrambler_DataOUT_VALID,
    input  logic              Scrambler_DataOUT_READY,
    output logic [15:0]       Scrambler_BitCount,
    output logic              Scrambler_SeedError
);

`ifdef SCRAMBLER_SEED_RECOVERY_EN
    typedef enum logic [1:0] {IDLE, RUN, ACQ} state_t;
    logic [2:0]        acq_cnt;
    logic [2:0]        acq_cnt_nxt;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t            state;
    logic [6:0]        lfsr;
    logic [6:0]        lfsr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              acq_nxt;
    logic              fb;
    logic              accept;
    logic [16:0]       cnt_sum;

    assign Scrambler_DataIN_READY = (state != IDLE) && !Scrambler_Start &&
                                    (!Scrambler_DataOUT_VALID || Scrambler_DataOUT_READY);
    assign accept              = Scrambler_DataIN_VALID && Scrambler_DataIN_READY;
    assign Scrambler_SeedError = (state == RUN) && (lfsr == 7'h00);
    assign cnt_sum             = {1'b0, Scrambler_BitCount} + 17'(DATA_W);

    // Bit-serial walk of one beat in time order; ACQ may hand over to RUN mid-beat.
    always_comb begin
        lfsr_nxt = lfsr;
        data_nxt = '0;
        fb       = 1'b0;
`ifdef SCRAMBLER_SEED_RECOVERY_EN
        acq_nxt     = (state == ACQ);
        acq_cnt_nxt = acq_cnt;
`else
        acq_nxt = 1'b0;
`endif
        for (int i = 0; i < DATA_W; i++) begin
            if (acq_nxt) begin
                lfsr_nxt = {lfsr_nxt[5:0],
                            Scrambler_DataIN[LSB_FIRST ? i : DATA_W-1-i]};
`ifdef SCRAMBLER_SEED_RECOVERY_EN
                acq_cnt_nxt = acq_cnt_nxt + 3'd1;
                if (acq_cnt_nxt == 3'd7)
                    acq_nxt = 1'b0;
`endif
            end else begin
                fb = lfsr_nxt[6] ^ lfsr_nxt[3];
                data_nxt[LSB_FIRST ? i : DATA_W-1-i] =
                    Scrambler_DataIN[LSB_FIRST ? i : DATA_W-1-i] ^ fb;
                lfsr_nxt = {lfsr_nxt[5:0], fb};
            end
        end
    end

    always_ff @(posedge clock or negedge Scrambler_Reset_n) begin
        if (!Scrambler_Reset_n) begin
            state                   <= IDLE;
            lfsr                    <= 7'h00;
            Scrambler_DataOUT       <= '0;
            Scrambler_DataOUT_VALID <= 1'b0;
            Scrambler_BitCount      <= 16'h0000;
`ifdef SCRAMBLER_SEED_RECOVERY_EN
            acq_cnt                 <= 3'd0;
`endif
        end else if (Scrambler_Start) begin
            Scrambler_DataOUT_VALID <= 1'b0;
            Scrambler_BitCount      <= 16'h0000;
`ifdef SCRAMBLER_SEED_RECOVERY_EN
            state                   <= ACQ;
            lfsr                    <= 7'h00;
            acq_cnt                 <= 3'd0;
`else
            state                   <= RUN;
            lfsr                    <= Scrambler_InitialState;
`endif
        end else if (accept) begin
            Scrambler_DataOUT       <= data_nxt;
            Scrambler_DataOUT_VALID <= 1'b1;
            lfsr                    <= lfsr_nxt;
            Scrambler_BitCount      <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
`ifdef SCRAMBLER_SEED_RECOVERY_EN
            acq_cnt                 <= acq_cnt_nxt;
            if (state == ACQ && !acq_nxt)
                state <= RUN;
`endif
        end else if (Scrambler_DataOUT_READY) begin
            Scrambler_DataOUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_parallel_scrambler.sv
// Scoreboard bench for parallel_scrambler (DATA_W=8, LSB first).
// Expected beats come from hand values and a 127-entry sequence table.
module tb_parallel_scrambler;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] init;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [15:0] bitcnt;
    logic       seed_err;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b1;
    logic [7:0] sb[$];

    parallel_scrambler #(.DATA_W(8), .LSB_FIRST(1'b1)) dut (
        .clock                   (clock),
        .Scrambler_Reset_n       (rst_n),
        .Scrambler_Start         (start),
        .Scrambler_InitialState  (init),
        .Scrambler_DataIN        (din),
        .Scrambler_DataIN_VALID  (din_valid),
        .Scrambler_DataIN_READY  (din_ready),
        .Scrambler_DataOUT       (dout),
        .Scrambler_DataOUT_VALID (dout_valid),
        .Scrambler_DataOUT_READY (dout_ready),
        .Scrambler_BitCount      (bitcnt),
        .Scrambler_SeedError     (seed_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Sequence f[n] = f[n-7] ^ f[n-4], seeded by the 7 prior feedback bits.
    function automatic logic [7:0] scr(input logic [6:0] seed, input int pos,
                                       input logic [7:0] d);
        logic ext [0:133];
        logic [7:0] r;
        for (int k = 0; k < 7; k++) ext[6-k] = seed[k];
        for (int j = 7; j < 134; j++) ext[j] = ext[j-7] ^ ext[j-4];
        r = d;
        for (int i = 0; i < 8; i++) r[i] = d[i] ^ ext[((pos + i) % 127) + 7];
        return r;
    endfunction

    always @(negedge clock) begin
        if (mon_en && dout_valid && dout_ready) begin
            if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
            else check("sb_data", dout, sb.pop_front());
        end
    end

    task automatic send(input logic [7:0] d, input logic [7:0] e);
        int t = 0;
        sb.push_back(e);
        din = d;
        din_valid = 1'b1;
        @(negedge clock);
        while (!din_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (!din_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1 din_valid = 1'b0;
    endtask

    task automatic do_start(input logic [6:0] seed);
        start = 1'b1;
        init = seed;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic realign();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pay;
        logic [7:0]  sc [8];
        logic [7:0]  ea;
        logic [7:0]  orig [4];
        rst_n = 1'b0;
        start = 1'b0;
        init = 7'h00;
        din = 8'h00;
        din_valid = 1'b1;
        dout_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_bitcnt", bitcnt, 0);
        check("rst_seed_err", seed_err, 0);
        check("rst_in_ready", din_ready, 0);
        din_valid = 1'b0;
        realign();

`ifdef SCRAMBLER_SEED_RECOVERY_EN
        orig[0] = 8'h80; orig[1] = 8'h3C; orig[2] = 8'hC5; orig[3] = 8'h19;
        do_start(7'h12);
        for (int k = 0; k < 4; k++) send(scr(7'h5D, 8*k, orig[k]), orig[k]);
        drain();
        check("acq_bitcnt", bitcnt, 32);
        check("acq_seed_err", seed_err, 0);
`else
        // All-zero data, seed 7F: hand values for the first 16 bits.
        do_start(7'h7F);
        send(8'h00, 8'h70);
        send(8'h00, 8'h4F);
        for (int k = 2; k < 18; k++) send(8'h00, scr(7'h7F, 8*k, 8'h00));
        drain();
        check("period_bitcnt", bitcnt, 144);
        realign();

        // Scramble then descramble a 64-bit stream.
        pay = 64'hD3A1_5E07_9CB4_62F8;
        do_start(7'h35);
        for (int k = 0; k < 8; k++) begin
            sc[k] = scr(7'h35, 8*k, pay[8*k +: 8]);
            send(pay[8*k +: 8], sc[k]);
        end
        drain();
        check("scr_bitcnt", bitcnt, 64);
        realign();
        do_start(7'h35);
        for (int k = 0; k < 8; k++) send(sc[k], pay[8*k +: 8]);
        drain();
        check("descr_bitcnt", bitcnt, 64);
        realign();

        // Downstream stall for 5 cycles.
        do_start(7'h11);
        dout_ready = 1'b0;
        ea = scr(7'h11, 0, 8'h12);
        send(8'h12, ea);
        fork
            send(8'h34, scr(7'h11, 8, 8'h34));
            begin
                repeat (5) begin
                    @(negedge clock);
                    check("stall_valid", dout_valid, 1);
                    check("stall_dout", dout, ea);
                    check("stall_ready", din_ready, 0);
                    check("stall_bitcnt", bitcnt, 8);
                end
                @(posedge clock);
                #1 dout_ready = 1'b1;
            end
        join
        drain();
        check("stall_bitcnt_end", bitcnt, 16);
        realign();

        // Start while a beat is stalled.
        do_start(7'h22);
        dout_ready = 1'b0;
        send(8'hFF, scr(7'h22, 0, 8'hFF));
        start = 1'b1;
        init = 7'h6B;
        din = 8'h5A;
        din_valid = 1'b1;
        @(negedge clock);
        check("start_in_ready", din_ready, 0);
        @(posedge clock);
        #1 start = 1'b0;
        din_valid = 1'b0;
        void'(sb.pop_back());
        @(negedge clock);
        check("restart_valid", dout_valid, 0);
        check("restart_bitcnt", bitcnt, 0);
        realign();
        dout_ready = 1'b1;
        send(8'h5A, scr(7'h6B, 0, 8'h5A));
        drain();
        realign();

        // Zero seed: pass-through with SeedError, then BitCount saturation.
        do_start(7'h00);
        @(negedge clock);
        check("zero_seed_err", seed_err, 1);
        realign();
        send(8'hA5, 8'hA5);
        send(8'h3C, 8'h3C);
        drain();
        realign();
        mon_en = 1'b0;
        din = 8'h00;
        din_valid = 1'b1;
        repeat (8200) @(posedge clock);
        #1 din_valid = 1'b0;
        @(negedge clock);
        check("sat_bitcnt", bitcnt, 16'hFFFF);
        check("sat_seed_err", seed_err, 1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
